pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencer for the five-stage pipeline: decides every cycle which pipeline latches (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) capture, hold, or load a bubble. It resolves instruction/data memory waits, load-use hazards, taken branches/jumps, and the halt/cache-flush drain. All latch `enable`/`flush` inputs in the datapath are driven only from this block.

## Interface
Parameters:
- `REGBITS`, 5, register index width
- `CNTW`, 16, stall counter width

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `ihit`  in  1  instruction fetch completes this cycle
- `dhit`  in  1  data access in MEM completes this cycle
- `mem_dREN`, `mem_dWEN`  in  1 each  EX/MEM stage holds a load / store
- `mem_halt`  in  1  EX/MEM stage holds a halt
- `ex_dREN`  in  1  ID/EX stage holds a load
- `ex_wsel`  in  REGBITS  destination of ID/EX instruction
- `id_rs`, `id_rt`  in  REGBITS  source fields of IF/ID instruction
- `ex_redirect`  in  1  ID/EX instruction's `pc_select` is not NEXT
- `dflush_done`  in  1  dcache write-back complete
- `pc_enable`, `ifid_enable`, `idex_enable`, `exmem_enable`, `memwb_enable`  out  1 each
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each
- `dflush_req`  out  1  request dcache write-back (registered)
- `halt`  out  1  processor halted, sticky (registered)
- `state`  out  2  current FSM state
- `stall_cycles`  out  CNTW  saturating count of front-end stall cycles

## Operation
- `mem_req = mem_dREN | mem_dWEN`; `lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt)`.
- FSM states: RUN=0, MEMWAIT=1, FLUSH=2, HALTED=3.
- RUN, first match wins:
  1. `mem_halt`: `memwb_enable=1`, `exmem_flush=1`, all other enables 0; next FLUSH.
  2. `mem_req & !dhit`: all enables 0, all flushes 0; next MEMWAIT.
  3. `mem_req & dhit`: `memwb_enable=1`, `exmem_flush=1`, PC/IF/ID/ID/EX held.
  4. `lu`: `pc_enable=0`, `ifid_enable=0`, `idex_flush=1`, `exmem_enable=memwb_enable=1`.
  5. Otherwise: `exmem_enable=memwb_enable=1`; if `ihit`: all enables 1, else `pc_enable=ifid_enable=0`, `idex_flush=1`.
  6. Overlay on 5 when `ex_redirect`: `pc_enable=1`, `ifid_flush=1`, `idex_flush=1`, regardless of `ihit`.
- MEMWAIT: `!dhit` holds everything; `dhit` applies rule 3 and returns to RUN.
- FLUSH: all enables 0; `dflush_req=1`; `dflush_done` moves to HALTED.
- HALTED: all enables 0, `halt=1` until reset.
- `stall_cycles` increments in RUN/MEMWAIT whenever `pc_enable=0` and the state is not FLUSH/HALTED; saturates at all-ones.
- Flush overrides enable at each latch; a latch never sees both flush and enable from this block in the same cycle except IF/ID/ID/EX under rule 6.

## Timing
- Enables/flushes are combinational from state and inputs; same-cycle effect at the next edge.
- `state`, `dflush_req`, `halt`, `stall_cycles` are registered.
- `dflush_req` rises on the first edge entering FLUSH and falls on the edge entering HALTED. `halt` rises on that same edge.
- Reset: state RUN, `dflush_req=0`, `halt=0`, `stall_cycles=0`. While `RST` is high, all enables and flushes are 0.
- Reset asserted mid-MEMWAIT or mid-FLUSH returns to RUN immediately. The pending request is abandoned.
- `dflush_done` outside FLUSH is ignored. `dhit` without `mem_req` is ignored.
- Load-use costs exactly one bubble. A taken redirect costs two squashed slots.

## Structure
- `cpu_types_pkg` gains `ctrl_state_t` (RUN, MEMWAIT, FLUSH, HALTED) and reuses `regbits_t`.
- Sub-module `load_use_detect`, purely combinational, producing `lu`.
- All other logic lives in one module: the next-state/output `always_comb` and the register `always_ff`.

## Test plan
- Load r3 in ID/EX, IF/ID uses rs=3, `ihit=1` -> one cycle with `pc_enable=0`, `idex_flush=1`; next cycle all enables 1. Same with `ex_wsel=0` -> no stall.
- `mem_dREN=1`, `dhit` low 3 cycles then high -> state MEMWAIT for 3 cycles with all enables 0. Then one cycle `memwb_enable=1`, `exmem_flush=1`, then RUN. `stall_cycles`=4.
- `ex_redirect=1` with `ihit=0` -> `pc_enable=1`, `ifid_flush=1`, `idex_flush=1`.
- `mem_halt=1` -> FLUSH with `dflush_req=1`. Hold `dflush_done=0` 5 cycles then pulse -> HALTED, `halt=1`, enables stay 0 for 10 more cycles.
- `RST` pulse mid-FLUSH -> state 0, `dflush_req=0`, `halt=0`, counter 0 asynchronously.
- Preload counter near all-ones, then force stalls -> counter holds at all-ones, no wrap.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and the pipeline controller state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2,
    HALTED  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination feeds a source of the IF/ID instruction.
module load_use_detect
  import cpu_types_pkg::*;
#(
  parameter int REGBITS = $bits(regbits_t)
) (
  input  logic               ex_dREN,
  input  logic [REGBITS-1:0] ex_wsel,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  output logic               lu
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign lu = ex_dREN && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle latch enables/flushes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB,
// covering memory waits, load-use bubbles, redirects and the halt/dcache-flush drain.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int CNTW    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_dREN,
  input  logic               mem_dWEN,
  input  logic               mem_halt,
  input  logic               ex_dREN,
  input  logic [REGBITS-1:0] ex_wsel,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic               ex_redirect,
  input  logic               dflush_done,
  output logic               pc_enable,
  output logic               ifid_enable,
  output logic               idex_enable,
  output logic               exmem_enable,
  output logic               memwb_enable,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               dflush_req,
  output logic               halt,
  output logic [1:0]         state,
  output logic [CNTW-1:0]    stall_cycles
);

  ctrl_state_t state_q, state_d;
  logic        lu;
  logic        mem_req;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;

  load_use_detect #(.REGBITS(REGBITS)) u_load_use_detect (
    .ex_dREN (ex_dREN),
    .ex_wsel (ex_wsel),
    .id_rs   (id_rs),
    .id_rt   (id_rt),
    .lu      (lu)
  );

  assign mem_req = mem_dREN | mem_dWEN;

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    idex_en  = 1'b0;
    exmem_en = 1'b0;
    memwb_en = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    memwb_fl = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_halt) begin
          // Retire the halt into MEM/WB and stop everything behind it.
          memwb_en = 1'b1;
          exmem_fl = 1'b1;
          state_d  = FLUSH;
        end else if (mem_req && !dhit) begin
          state_d = MEMWAIT;
        end else if (mem_req) begin
          memwb_en = 1'b1;
          exmem_fl = 1'b1;
        end else if (lu) begin
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          idex_fl  = 1'b1;
        end else begin
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (ihit) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
          end else begin
            idex_fl = 1'b1;
          end
          // Redirect squashes the two younger slots and lets the new PC load at once.
          if (ex_redirect) begin
            pc_en   = 1'b1;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
          end
        end
      end
      MEMWAIT: begin
        if (dhit) begin
          memwb_en = 1'b1;
          exmem_fl = 1'b1;
          state_d  = RUN;
        end
      end
      FLUSH: begin
        if (dflush_done) state_d = HALTED;
      end
      HALTED: begin
      end
      default: state_d = RUN;
    endcase
  end

  // Reset must not let any latch move, so gate the decoded controls with RST.
  assign pc_enable    = pc_en    & ~RST;
  assign ifid_enable  = ifid_en  & ~RST;
  assign idex_enable  = idex_en  & ~RST;
  assign exmem_enable = exmem_en & ~RST;
  assign memwb_enable = memwb_en & ~RST;
  assign ifid_flush   = ifid_fl  & ~RST;
  assign idex_flush   = idex_fl  & ~RST;
  assign exmem_flush  = exmem_fl & ~RST;
  assign memwb_flush  = memwb_fl & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= RUN;
      dflush_req   <= 1'b0;
      halt         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q    <= state_d;
      dflush_req <= (state_d == FLUSH);
      halt       <= (state_d == HALTED);
      if (((state_q == RUN) || (state_q == MEMWAIT)) && !pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected controls and registered state queued per step.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_redirect, dflush_done;
  logic [4:0] ex_wsel, id_rs, id_rt;

  logic        pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        dflush_req, halt;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_fl, s_idex_fl, s_exmem_fl, s_memwb_fl;
  logic        s_dflush_req, s_halt;
  logic [1:0]  s_state;
  logic [3:0]  s_stall;

  logic [8:0]  ctl_q[$];
  logic [19:0] reg_q[$];
  int          checks = 0;
  int          fails  = 0;

  // Expected control vectors: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  localparam logic [8:0] C_NONE   = 9'b00000_0000;
  localparam logic [8:0] C_ALL    = 9'b11111_0000;
  localparam logic [8:0] C_BUBBLE = 9'b00011_0100;
  localparam logic [8:0] C_MEMDN  = 9'b00001_0010;
  localparam logic [8:0] C_REDIR0 = 9'b10011_1100;
  localparam logic [8:0] C_REDIR1 = 9'b11111_1100;
  // Expected {state, dflush_req, halt}
  localparam logic [3:0] R_RUN  = 4'b0000;
  localparam logic [3:0] R_MW   = 4'b0100;
  localparam logic [3:0] R_FL   = 4'b1010;
  localparam logic [3:0] R_HALT = 4'b1101;

  wire [8:0] ctl_obs = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                        ifid_flush, idex_flush, exmem_flush, memwb_flush};

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.REGBITS(5), .CNTW(16)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .ex_redirect(ex_redirect), .dflush_done(dflush_done),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .dflush_req(dflush_req), .halt(halt),
    .state(state), .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance used to reach saturation quickly.
  pipeline_ctrl #(.REGBITS(5), .CNTW(4)) dut_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .ex_redirect(ex_redirect), .dflush_done(dflush_done),
    .pc_enable(s_pc_en), .ifid_enable(s_ifid_en), .idex_enable(s_idex_en),
    .exmem_enable(s_exmem_en), .memwb_enable(s_memwb_en),
    .ifid_flush(s_ifid_fl), .idex_flush(s_idex_fl), .exmem_flush(s_exmem_fl),
    .memwb_flush(s_memwb_fl), .dflush_req(s_dflush_req), .halt(s_halt),
    .state(s_state), .stall_cycles(s_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    ex_dREN = 1'b0; ex_redirect = 1'b0; dflush_done = 1'b0;
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  // Called at posedge+1 with inputs already driven: checks controls mid-cycle, registers after the edge.
  task automatic cyc(input string tag, input logic [8:0] ec, input logic [3:0] er, input logic [15:0] es);
    ctl_q.push_back(ec);
    reg_q.push_back({er, es});
    #4;
    chk({tag, ":ctl"}, {23'd0, ctl_obs}, {23'd0, ctl_q.pop_front()});
    @(posedge CLK);
    #1;
    chk({tag, ":reg"}, {12'd0, state, dflush_req, halt, stall_cycles}, {12'd0, reg_q.pop_front()});
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    @(posedge CLK);
    #1;
    cyc("reset", C_NONE, R_RUN, 16'd0);
    RST = 1'b0;

    cyc("idle_hit", C_ALL, R_RUN, 16'd0);
    ihit = 1'b0;
    cyc("imiss", C_BUBBLE, R_RUN, 16'd1);

    ihit = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3; id_rt = 5'd9;
    cyc("lu_rs", C_BUBBLE, R_RUN, 16'd2);
    ex_dREN = 1'b0;
    cyc("lu_after", C_ALL, R_RUN, 16'd2);

    ex_dREN = 1'b1; ex_wsel = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    cyc("lu_rt", C_BUBBLE, R_RUN, 16'd3);
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cyc("lu_r0", C_ALL, R_RUN, 16'd3);
    ex_wsel = 5'd5; id_rs = 5'd6; id_rt = 5'd4;
    cyc("lu_nomatch", C_ALL, R_RUN, 16'd3);
    ex_dREN = 1'b0;

    ex_redirect = 1'b1; ihit = 1'b0;
    cyc("redir_miss", C_REDIR0, R_RUN, 16'd3);
    ihit = 1'b1;
    cyc("redir_hit", C_REDIR1, R_RUN, 16'd3);
    ex_dREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
    cyc("lu_over_redir", C_BUBBLE, R_RUN, 16'd4);
    idle_inputs();

    dhit = 1'b1;
    cyc("dhit_noreq", C_ALL, R_RUN, 16'd4);
    mem_dWEN = 1'b1;
    cyc("store_hit", C_MEMDN, R_RUN, 16'd5);
    mem_dWEN = 1'b0; mem_dREN = 1'b1; dhit = 1'b0;
    cyc("load_miss0", C_NONE, R_MW, 16'd6);
    cyc("load_miss1", C_NONE, R_MW, 16'd7);
    ihit = 1'b0;
    cyc("load_miss2", C_NONE, R_MW, 16'd8);
    dhit = 1'b1;
    cyc("load_done", C_MEMDN, R_RUN, 16'd9);
    idle_inputs();

    dflush_done = 1'b1;
    cyc("dfd_ignored", C_ALL, R_RUN, 16'd9);
    dflush_done = 1'b0; mem_halt = 1'b1;
    cyc("halt_enter", C_MEMDN, R_FL, 16'd10);
    mem_halt = 1'b0;
    for (int i = 0; i < 5; i++) cyc("flush_wait", C_NONE, R_FL, 16'd10);
    dflush_done = 1'b1;
    cyc("flush_done", C_NONE, R_HALT, 16'd10);
    dflush_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
      mem_dREN = 1'($urandom_range(0, 1)); ex_redirect = 1'($urandom_range(0, 1));
      mem_halt = 1'($urandom_range(0, 1)); dflush_done = 1'($urandom_range(0, 1));
      cyc("halted", C_NONE, R_HALT, 16'd10);
    end
    idle_inputs();

    RST = 1'b1;
    cyc("rst_from_halt", C_NONE, R_RUN, 16'd0);
    RST = 1'b0;
    mem_halt = 1'b1;
    cyc("halt_again", C_MEMDN, R_FL, 16'd1);
    mem_halt = 1'b0;
    cyc("flush_mid", C_NONE, R_FL, 16'd1);
    #4;
    RST = 1'b1;
    reg_q.push_back({R_RUN, 16'd0});
    #1;
    chk("async_rst", {12'd0, state, dflush_req, halt, stall_cycles}, {12'd0, reg_q.pop_front()});
    @(posedge CLK);
    #1;
    RST = 1'b0;

    ihit = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc("sat_main", C_BUBBLE, R_RUN, 16'(i));
      chk("sat_narrow", {28'd0, s_stall}, (i > 15) ? 32'd15 : 32'(i));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
